// File: rtl/key_scan.sv
// Scans a 4x4 active-low keypad and emits debounced key codes; `define KEY_REPEAT_EN adds auto-repeat pulses while a key is held.
// Latency: O_valid rises within (DEBOUNCE_SCANS+1) full scans + 3 cycles of a stable press.
// Backpressure: none; O_valid is a one-cycle strobe and O_pressed a level the core samples at will.
module key_scan #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 64
) (
    input  logic       I_clk,
    input  logic       I_rst_n,
    input  logic [3:0] I_col,
    output logic [3:0] O_row,
    output logic [3:0] O_key,
    output logic       O_valid,
    output logic       O_pressed
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;
    typedef enum logic [1:0] {CLS_NONE, CLS_ONE, CLS_MULTI} cls_t;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [3:0]    row_q, row_d;
    logic [3:0]    col_s1_q, col_s1_d, col_s2_q, col_s2_d;
    logic [15:0]   snap_q, snap_d;
    logic          scan_done_q, scan_done_d;
    cls_t          prev_cls_q, prev_cls_d;
    logic [3:0]    prev_code_q, prev_code_d;
    logic [DW-1:0] deb_q, deb_d;
    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_q, key_d;
    logic          valid_q, valid_d;
    logic          pressed_q, pressed_d;
`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);
    logic [RW-1:0] rep_q, rep_d;
`endif

    logic       slot_end;
    logic [4:0] nkeys;
    logic [3:0] code_c;
    cls_t       cls_c;
    logic       same_c;
    logic       deb_sat;

    assign slot_end = (cnt_q == CW'(SCAN_DIV - 1));

    // Slot timing, row drive, column synchronizer and per-row snapshot.
    always_comb begin
        col_s1_d    = I_col;
        col_s2_d    = col_s1_q;
        cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
        row_idx_d   = slot_end ? row_idx_q + 2'd1 : row_idx_q;
        scan_done_d = slot_end && (row_idx_q == 2'd3);
        snap_d      = snap_q;
        case (row_idx_d)
            2'd0:    row_d = 4'b0111;
            2'd1:    row_d = 4'b1011;
            2'd2:    row_d = 4'b1101;
            default: row_d = 4'b1110;
        endcase
        if (slot_end) begin
            for (int c = 0; c < 4; c++) begin
                snap_d[{row_idx_q, 2'(c)}] = ~col_s2_q[3 - c];
            end
        end
    end

    always_comb begin
        nkeys  = '0;
        code_c = '0;
        for (int k = 0; k < 16; k++) begin
            nkeys = nkeys + {4'd0, snap_q[k]};
            if (snap_q[k]) code_c = 4'(k);
        end
        if (nkeys == 5'd0)      cls_c = CLS_NONE;
        else if (nkeys == 5'd1) cls_c = CLS_ONE;
        else                    cls_c = CLS_MULTI;
    end

    // Two ONE scans only match when they saw the same key.
    always_comb begin
        same_c      = (cls_c == prev_cls_q) && ((cls_c != CLS_ONE) || (code_c == prev_code_q));
        prev_cls_d  = prev_cls_q;
        prev_code_d = prev_code_q;
        deb_d       = deb_q;
        if (scan_done_q) begin
            prev_cls_d  = cls_c;
            prev_code_d = code_c;
            if (!same_c)                              deb_d = DW'(1);
            else if (deb_q != DW'(DEBOUNCE_SCANS))    deb_d = deb_q + 1'b1;
        end
        deb_sat = (deb_d == DW'(DEBOUNCE_SCANS));
    end

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        key_d     = key_q;
        valid_d   = 1'b0;
        pressed_d = pressed_q;
`ifdef KEY_REPEAT_EN
        rep_d     = rep_q;
`endif
        case (state_q)
            IDLE: begin
                if (scan_done_q && cls_c == CLS_ONE) begin
                    cand_d = code_c;
                    if (deb_sat) begin
                        state_d   = HELD;
                        key_d     = code_c;
                        valid_d   = 1'b1;
                        pressed_d = 1'b1;
`ifdef KEY_REPEAT_EN
                        rep_d     = '0;
`endif
                    end else begin
                        state_d = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (scan_done_q) begin
                    if (cls_c == CLS_ONE && code_c == cand_q) begin
                        if (deb_sat) begin
                            state_d   = HELD;
                            key_d     = cand_q;
                            valid_d   = 1'b1;
                            pressed_d = 1'b1;
`ifdef KEY_REPEAT_EN
                            rep_d     = '0;
`endif
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HELD: begin
                // Any other key or a multi-key chord still counts as holding the accepted key.
                if (scan_done_q) begin
                    if (cls_c == CLS_NONE) begin
                        if (deb_sat) begin
                            state_d   = IDLE;
                            pressed_d = 1'b0;
                        end
`ifdef KEY_REPEAT_EN
                    end else if (rep_q == RW'(REPEAT_SCANS - 1)) begin
                        rep_d   = '0;
                        valid_d = 1'b1;
                    end else begin
                        rep_d = rep_q + 1'b1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            cnt_q       <= '0;
            row_idx_q   <= 2'd0;
            row_q       <= 4'b0111;
            col_s1_q    <= 4'hF;
            col_s2_q    <= 4'hF;
            snap_q      <= '0;
            scan_done_q <= 1'b0;
            prev_cls_q  <= CLS_NONE;
            prev_code_q <= '0;
            deb_q       <= '0;
            state_q     <= IDLE;
            cand_q      <= '0;
            key_q       <= '0;
            valid_q     <= 1'b0;
            pressed_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            row_idx_q   <= row_idx_d;
            row_q       <= row_d;
            col_s1_q    <= col_s1_d;
            col_s2_q    <= col_s2_d;
            snap_q      <= snap_d;
            scan_done_q <= scan_done_d;
            prev_cls_q  <= prev_cls_d;
            prev_code_q <= prev_code_d;
            deb_q       <= deb_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            key_q       <= key_d;
            valid_q     <= valid_d;
            pressed_q   <= pressed_d;
`ifdef KEY_REPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    assign O_row     = row_q;
    assign O_key     = key_q;
    assign O_valid   = valid_q;
    assign O_pressed = pressed_q;

endmodule
